// File: rtl/frog_sequencer.sv
// Sequencing controller for the serial-programmed frog LFSR core: clear, serial load, run, park, scrub.
// Optional FROG_SEQ_ZERO_GUARD_EN rejects all-zero taps/seed with an err pulse instead of running.
module frog_sequencer #(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_taps,
  input  logic [N-1:0]  cfg_seed,
  input  logic [CW-1:0] cfg_count,
  input  logic          abort,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [W-1:0]  word_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          chip_rst_n,
  output logic          chip_load,
  output logic          chip_test,
  output logic          chip_program,
  output logic          chip_seed,
  input  logic          chip_out
);
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, PARK, SCRUB} state_t;

  state_t        state;
  logic [N-1:0]  taps_q, seed_q;
  logic [CW-1:0] remain;
  logic [NW-1:0] idx;
  logic [NW-1:0] idx_next;
  logic [BW-1:0] bitcnt;
  logic [W-1:0]  shreg, held, cap_word, out_word;
  logic          park_q, seed_bit;
  logic          slot_free, last_word, reject;

  assign slot_free = !word_valid || word_ready;
  assign last_word = (remain <= CW'(1));
  assign idx_next  = (idx == NW'(N - 1)) ? '0 : NW'(idx + 1'b1);
  assign out_word  = (state == PARK) ? held : cap_word;

  // While parked the core's own output is fed straight back in, so the rotation
  // loses no bit; a registered copy would lag by one cycle and corrupt the state.
  assign chip_seed = park_q ? chip_out : seed_bit;

`ifdef FROG_SEQ_ZERO_GUARD_EN
  assign reject = (cfg_taps == '0) || (cfg_seed == '0);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    cap_word         = shreg;
    cap_word[bitcnt] = chip_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      taps_q       <= '0;
      seed_q       <= '0;
      remain       <= '0;
      idx          <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      held         <= '0;
      park_q       <= 1'b0;
      seed_bit     <= 1'b0;
      cfg_ready    <= 1'b0;
      word_valid   <= 1'b0;
      word_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      chip_rst_n   <= 1'b0;
      chip_load    <= 1'b0;
      chip_test    <= 1'b0;
      chip_program <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (word_valid && word_ready) word_valid <= 1'b0;

      if (abort && (state inside {CLEAR, LOAD, RUN, PARK})) begin
        state        <= SCRUB;
        idx          <= '0;
        park_q       <= 1'b0;
        seed_bit     <= 1'b0;
        chip_rst_n   <= 1'b1;
        chip_load    <= 1'b0;
        chip_test    <= 1'b1;
        chip_program <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cfg_ready  <= 1'b1;
            chip_rst_n <= 1'b1;
            if (cfg_valid && cfg_ready) begin
              if (reject) begin
                err <= 1'b1;
              end else begin
                taps_q     <= cfg_taps;
                seed_q     <= cfg_seed;
                remain     <= cfg_count;
                state      <= CLEAR;
                busy       <= 1'b1;
                cfg_ready  <= 1'b0;
                chip_rst_n <= 1'b0;
              end
            end
          end
          CLEAR: begin
            state        <= LOAD;
            idx          <= '0;
            chip_rst_n   <= 1'b1;
            chip_load    <= 1'b1;
            chip_program <= taps_q[0];
            seed_bit     <= seed_q[0];
          end
          LOAD: begin
            if (idx == NW'(N - 1)) begin
              chip_load    <= 1'b0;
              chip_program <= 1'b0;
              seed_bit     <= 1'b0;
              bitcnt       <= '0;
              if (remain == '0) begin
                state     <= IDLE;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
                done      <= 1'b1;
              end else begin
                state <= RUN;
              end
            end else begin
              idx          <= idx_next;
              chip_program <= taps_q[idx_next];
              seed_bit     <= seed_q[idx_next];
            end
          end
          RUN, PARK: begin
            if (state == RUN) shreg <= cap_word;
            if ((state == RUN && bitcnt == BW'(W - 1) && slot_free) ||
                (state == PARK && idx == NW'(N - 1) && slot_free)) begin
              // A finished word (fresh or parked) moves into the output slot.
              word_data    <= out_word;
              word_valid   <= 1'b1;
              bitcnt       <= '0;
              park_q       <= 1'b0;
              chip_load    <= 1'b0;
              chip_program <= 1'b0;
              if (remain != '0) remain <= remain - CW'(1);
              if (last_word) begin
                state     <= IDLE;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
                done      <= 1'b1;
              end else begin
                state <= RUN;
              end
            end else if (state == RUN && bitcnt == BW'(W - 1)) begin
              state        <= PARK;
              held         <= cap_word;
              bitcnt       <= '0;
              idx          <= '0;
              park_q       <= 1'b1;
              chip_load    <= 1'b1;
              chip_program <= taps_q[0];
            end else if (state == RUN) begin
              bitcnt <= bitcnt + BW'(1);
            end else begin
              idx          <= idx_next;
              chip_program <= taps_q[idx_next];
            end
          end
          SCRUB: begin
            if (idx == NW'(N - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cfg_ready <= 1'b1;
              chip_test <= 1'b0;
            end else begin
              idx <= idx_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
